// File: rtl/mux_nchan_bbm_if.sv
// Bus bundle for mux_nchan_bbm: select/gate/data in, steered output and status out.
// MUX_NY_EN adds the inverted output ny.
interface mux_nchan_bbm_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
);
    logic [SELW-1:0]           sel;
    logic                      sel_stb;
    logic                      ng;
    logic [CHANNELS*WIDTH-1:0] d;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic                      busy;
    logic                      sel_err;
`ifdef MUX_NY_EN
    logic [WIDTH-1:0]          ny;
`endif

    modport master (
        output sel, sel_stb, ng, d,
`ifdef MUX_NY_EN
        input  ny,
`endif
        input  y, y_valid, busy, sel_err
    );

    modport slave (
        input  sel, sel_stb, ng, d,
`ifdef MUX_NY_EN
        output ny,
`endif
        output y, y_valid, busy, sel_err
    );
endinterface

// File: rtl/mux_nchan_bbm.sv
// Registered N-channel bus mux with break-before-make select changeover and active-low gate.
// Optional MUX_NY_EN adds an inverted output ny with the same timing as y.
module mux_nchan_bbm #(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SELW         = 2,
    parameter int unsigned BREAK_CYCLES = 1
) (
    input logic              clk,
    input logic              nreset,
    mux_nchan_bbm_if.slave   bus
);

    localparam int unsigned NumSlots = 1 << SELW;

    typedef enum logic [1:0] {StOff, StBrk, StDrv} state_e;

    state_e           state_q, state_d;
    logic [SELW-1:0]  cur_sel_q, cur_sel_d;
    logic [SELW-1:0]  pend_sel_q, pend_sel_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             sel_err_q, sel_err_d;
    logic             sel_in_range;
    logic             stb_ok;
    logic             stb_bad;
    logic             drive;
    logic [WIDTH-1:0] chan [NumSlots];

    // Unused select codes read as zero; cur_sel never reaches them.
    for (genvar k = 0; k < NumSlots; k++) begin : g_chan
        if (k < CHANNELS) begin : g_used
            assign chan[k] = bus.d[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    assign sel_in_range = (32'(bus.sel) < CHANNELS);
    assign stb_ok       = bus.sel_stb & sel_in_range;
    assign stb_bad      = bus.sel_stb & ~sel_in_range;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StOff;
            cur_sel_q  <= '0;
            pend_sel_q <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            pend_sel_q <= pend_sel_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            sel_err_q  <= sel_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        cnt_d      = cnt_q;
        sel_err_d  = sel_err_q | stb_bad;
        if (bus.ng) begin
            // Gate off wins; a changeover in flight still lands on its pending channel.
            state_d = StOff;
            if (state_q == StBrk) cur_sel_d = pend_sel_q;
            if (stb_ok)           cur_sel_d = bus.sel;
        end else begin
            unique case (state_q)
                StOff: begin
                    state_d = StDrv;
                    if (stb_ok) cur_sel_d = bus.sel;
                end
                StDrv: begin
                    if (stb_ok && (bus.sel != cur_sel_q)) begin
                        if (BREAK_CYCLES == 0) begin
                            cur_sel_d = bus.sel;
                        end else begin
                            pend_sel_d = bus.sel;
                            cnt_d      = 4'(BREAK_CYCLES);
                            state_d    = StBrk;
                        end
                    end
                end
                StBrk: begin
                    if (stb_ok) begin
                        pend_sel_d = bus.sel;
                        cnt_d      = 4'(BREAK_CYCLES);
                    end else if (cnt_q <= 4'd1) begin
                        cur_sel_d = pend_sel_q;
                        cnt_d     = '0;
                        state_d   = StDrv;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = StOff;
            endcase
        end
    end

    // Sample through the post-edge selection so a new channel is valid on its first drive cycle.
    assign y_d = chan[cur_sel_d];

    always_comb begin
        drive       = (state_q == StDrv);
        bus.y_valid = drive;
        bus.busy    = (state_q == StBrk);
        bus.sel_err = sel_err_q;
    end

    assign bus.y = drive ? y_q : {WIDTH{1'bz}};

`ifdef MUX_NY_EN
    assign bus.ny = drive ? ~y_q : {WIDTH{1'bz}};
`endif

endmodule
